direcc_sprite_param: RTL and testbench

DIRECC_SPRITE_PARAM -- requirements
Module: direcc_sprite_param

---
 rtl/direcc_pkg.sv | 35 +++
 rtl/direcc_cfg_shadow.sv | 54 +++++
 rtl/direcc_sprite_param.sv | 105 ++++++++++
 tb/tb_direcc_sprite_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/direcc_pkg.sv
// Shared constants and types for the sprite address generator.
//   BP_X_DEF / BP_Y_DEF : default back porches (columns / rows)
//   COL_W / ROW_W       : scan coordinate widths
//   DELTA_W             : signed width of the origin-relative deltas
//   escala_e            : magnification encodings (log2)
//   cfg_t               : sprite configuration tuple
package direcc_pkg;

   localparam int unsigned BP_X_DEF = 216;
   localparam int unsigned BP_Y_DEF = 35;
   localparam int unsigned COL_W    = 11;
   localparam int unsigned ROW_W    = 10;
   localparam int unsigned DELTA_W  = 13;

   typedef enum logic [1:0] {
      EscX1    = 2'd0,
      EscX2    = 2'd1,
      EscX4    = 2'd2,
      EscX4Alt = 2'd3
   } escala_e;

   typedef struct packed {
      logic [COL_W-1:0] origen_x;
      logic [ROW_W-1:0] origen_y;
      logic [1:0]       escala;
   } cfg_t;

   localparam cfg_t CFG_RESET = '{origen_x: '0, origen_y: '0, escala: 2'(EscX2)};

   // Encoding 3 has no x8 meaning; it behaves as x4.
   function automatic logic [1:0] escala_eff(input logic [1:0] esc);
      return (esc == 2'(EscX4Alt)) ? 2'(EscX4) : esc;
   endfunction

endpackage

// File: rtl/direcc_cfg_shadow.sv
// Pending/active configuration double buffer.
//   clk, rst_n    : clock, async active-low reset
//   cfg_valid     : configuration offer
//   cfg_ready     : pending slot free
//   cfg_in        : offered configuration tuple
//   inicio_trama  : frame-start pulse; promotes pending to active
//   active        : configuration used by the datapath
module direcc_cfg_shadow
   import direcc_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic cfg_valid,
   output logic cfg_ready,
   input  cfg_t cfg_in,
   input  logic inicio_trama,
   output cfg_t active
);

   cfg_t pending_q, pending_d;
   cfg_t active_q, active_d;
   logic pend_q, pend_d;

   always_comb begin
      pending_d = pending_q;
      active_d  = active_q;
      pend_d    = pend_q;
      // A slot filled in the same cycle as inicio_trama waits for the next frame
      // because promotion only looks at the already-registered pending flag.
      if (inicio_trama && pend_q) begin
         active_d = pending_q;
         pend_d   = 1'b0;
      end else if (cfg_valid && !pend_q) begin
         pending_d = cfg_in;
         pend_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         active_q  <= CFG_RESET;
         pend_q    <= 1'b0;
      end else begin
         pending_q <= pending_d;
         active_q  <= active_d;
         pend_q    <= pend_d;
      end
   end

   assign cfg_ready = ~pend_q;
   assign active    = active_q;

endmodule

// File: rtl/direcc_sprite_param.sv
// Sprite ROM address generator: maps the scan position to a texel address of a
// magnified sprite placed at a configurable origin. Two pix_en-gated stages.
//   clk, rst_n              : clock, async active-low reset
//   pix_en                  : pixel-rate enable
//   Filas, Columnas         : current scan row / column
//   inicio_trama            : frame-start pulse
//   cfg_valid / cfg_ready   : configuration handshake
//   cfg_origen_x/_y, cfg_escala : offered configuration
//   Address, addr_valid     : {row texel, column texel} and in-window flag
module direcc_sprite_param
   import direcc_pkg::*;
#(
   parameter int unsigned AX   = 3,
   parameter int unsigned AY   = 3,
   parameter int unsigned BP_X = BP_X_DEF,
   parameter int unsigned BP_Y = BP_Y_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pix_en,
   input  logic [ROW_W-1:0]   Filas,
   input  logic [COL_W-1:0]   Columnas,
   input  logic               inicio_trama,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [COL_W-1:0]   cfg_origen_x,
   input  logic [ROW_W-1:0]   cfg_origen_y,
   input  logic [1:0]         cfg_escala,
   output logic [AX+AY-1:0]   Address,
   output logic               addr_valid
);

   localparam int unsigned DW = DELTA_W;

   cfg_t cfg_in, act;

   assign cfg_in = '{origen_x: cfg_origen_x, origen_y: cfg_origen_y, escala: cfg_escala};

   direcc_cfg_shadow u_cfg_shadow (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_in       (cfg_in),
      .inicio_trama (inicio_trama),
      .active       (act)
   );

   // Stage 1: origin-relative deltas and window test.
   logic [DW-1:0] dx, dy, lim_x, lim_y;
   logic [1:0]    esc;
   logic          in_win;

   assign dx  = DW'(Columnas) - DW'(BP_X) - DW'(act.origen_x);
   assign dy  = DW'(Filas) - DW'(BP_Y) - DW'(act.origen_y);
   assign esc = escala_eff(act.escala);

   assign lim_x = DW'(1 << AX) << esc;
   assign lim_y = DW'(1 << AY) << esc;

   // The MSB is the sign; a negative delta never passes.
   assign in_win = !dx[DW-1] && !dy[DW-1] && (dx < lim_x) && (dy < lim_y);

   logic [DW-1:0] s1_dx_q, s1_dy_q;
   logic [1:0]    s1_esc_q;
   logic          s1_in_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_dx_q  <= '0;
         s1_dy_q  <= '0;
         s1_esc_q <= '0;
         s1_in_q  <= 1'b0;
      end else if (pix_en) begin
         s1_dx_q  <= dx;
         s1_dy_q  <= dy;
         s1_esc_q <= esc;
         s1_in_q  <= in_win;
      end
   end

   // Stage 2: demagnify by shifting with the scale the pixel entered with.
   logic [AX-1:0]    tex_x;
   logic [AY-1:0]    tex_y;
   logic [AX+AY-1:0] addr_d, addr_q;
   logic             vld_q;

   assign tex_x  = AX'(s1_dx_q >> s1_esc_q);
   assign tex_y  = AY'(s1_dy_q >> s1_esc_q);
   assign addr_d = s1_in_q ? {tex_y, tex_x} : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         vld_q  <= 1'b0;
      end else if (pix_en) begin
         addr_q <= addr_d;
         vld_q  <= s1_in_q;
      end
   end

   assign Address    = addr_q;
   assign addr_valid = vld_q;

endmodule

// File: tb/tb_direcc_sprite_param.sv
module tb_direcc_sprite_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pix_en;
   logic [9:0]  Filas;
   logic [10:0] Columnas;
   logic        inicio_trama;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [10:0] cfg_origen_x;
   logic [9:0]  cfg_origen_y;
   logic [1:0]  cfg_escala;
   logic [5:0]  Address;
   logic        addr_valid;

   direcc_sprite_param dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pix_en       (pix_en),
      .Filas        (Filas),
      .Columnas     (Columnas),
      .inicio_trama (inicio_trama),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_origen_x (cfg_origen_x),
      .cfg_origen_y (cfg_origen_y),
      .cfg_escala   (cfg_escala),
      .Address      (Address),
      .addr_valid   (addr_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] addr;
      logic       vld;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   n_en  = 0;

   task automatic chk(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, want);
      end
   endtask

   // Monitor: every enabled edge presents the vector issued one enabled edge earlier.
   always @(posedge clk) begin
      if (rst_n && pix_en) begin
         n_en++;
         if (n_en >= 2) begin
            #1;
            if (exp_q.size() == 0) begin
               chk("scoreboard_empty", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk({e.name, "_addr"}, int'(Address), int'(e.addr));
               chk({e.name, "_vld"}, int'(addr_valid), int'(e.vld));
            end
         end
      end
   end

   task automatic pix(input int col, input int row, input int ea, input bit ev,
                      input string nm);
      exp_t e;
      @(negedge clk);
      Columnas = 11'(col);
      Filas    = 10'(row);
      pix_en   = 1'b1;
      e.addr   = 6'(ea);
      e.vld    = ev;
      e.name   = nm;
      exp_q.push_back(e);
   endtask

   task automatic offer(input int ox, input int oy, input int es, input bit frame);
      @(negedge clk);
      pix_en       = 1'b0;
      cfg_valid    = 1'b1;
      cfg_origen_x = 11'(ox);
      cfg_origen_y = 10'(oy);
      cfg_escala   = 2'(es);
      inicio_trama = frame;
      @(negedge clk);
      cfg_valid    = 1'b0;
      inicio_trama = 1'b0;
   endtask

   task automatic frame_start();
      @(negedge clk);
      pix_en       = 1'b0;
      inicio_trama = 1'b1;
      @(negedge clk);
      inicio_trama = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      pix_en       = 1'b0;
      Filas        = '0;
      Columnas     = '0;
      inicio_trama = 1'b0;
      cfg_valid    = 1'b0;
      cfg_origen_x = '0;
      cfg_origen_y = '0;
      cfg_escala   = '0;
      #12;
      chk("reset_addr", int'(Address), 0);
      chk("reset_vld", int'(addr_valid), 0);
      chk("reset_ready", int'(cfg_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Defaults: origin (0,0), x2.
      pix(221, 42, 26, 1, "default_26");
      pix(232, 42, 0, 0, "dx_edge16");
      pix(215, 42, 0, 0, "dx_negative");
      pix(221, 50, 58, 1, "dy_15");
      pix(221, 51, 0, 0, "dy_edge16");

      // Hold: A then B, then 5 disabled cycles with moving coordinates.
      pix(221, 42, 26, 1, "hold_a");
      pix(223, 44, 35, 1, "hold_b");
      @(negedge clk);
      pix_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         Columnas = 11'(300 + i);
         Filas    = 10'(100 + i);
         @(negedge clk);
         chk("hold_addr", int'(Address), 26);
         chk("hold_vld", int'(addr_valid), 1);
      end
      pix(215, 42, 0, 0, "hold_c");
      pix(221, 42, 26, 1, "hold_d");

      // Origin (100,20), x4.
      offer(100, 20, 2, 1'b0);
      chk("ready_after_offer", int'(cfg_ready), 0);
      frame_start();
      chk("ready_after_frame", int'(cfg_ready), 1);
      pix(329, 85, 59, 1, "cfg_59");

      // Offer coincident with frame start: stays pending.
      offer(0, 0, 0, 1'b1);
      chk("ready_same_cycle", int'(cfg_ready), 0);
      offer(50, 50, 1, 1'b0);
      chk("ready_still_busy", int'(cfg_ready), 0);
      pix(329, 85, 59, 1, "old_cfg_kept");
      pix(221, 42, 0, 0, "old_cfg_neg");
      frame_start();
      chk("ready_after_promote", int'(cfg_ready), 1);
      pix(221, 42, 61, 1, "esc0_61");
      pix(224, 42, 0, 0, "esc0_edge8");
      pix(223, 42, 63, 1, "esc0_max");

      // Encoding 3 behaves as x4.
      offer(0, 0, 3, 1'b0);
      frame_start();
      pix(247, 66, 63, 1, "esc3_63");
      pix(248, 66, 0, 0, "esc3_edge32");
      pix(247, 66, 63, 1, "esc3_again");
      pix(0, 0, 0, 0, "neg_both");

      // Reset with valid output and a pending configuration.
      offer(300, 300, 0, 1'b0);
      chk("ready_pending", int'(cfg_ready), 0);
      chk("pre_reset_vld", int'(addr_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_addr", int'(Address), 0);
      chk("midreset_vld", int'(addr_valid), 0);
      chk("midreset_ready", int'(cfg_ready), 1);
      exp_q.delete();
      n_en = 0;
      @(negedge clk);
      rst_n = 1'b1;
      frame_start();
      chk("ready_post_reset", int'(cfg_ready), 1);
      pix(221, 42, 26, 1, "post_reset_26");
      pix(221, 50, 58, 1, "post_reset_58");
      pix(221, 51, 0, 0, "post_reset_edge");
      pix(0, 0, 0, 0, "flush1");
      pix(0, 0, 0, 0, "flush2");
      @(negedge clk);
      pix_en = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
